// File: rtl/avr_pkg.sv
// Shared types and default constants for the AVR data-memory arbiter.
package avr_pkg;

    // Arbiter FSM states: waiting for a request, or holding a multi-cycle access
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_A = 2'd1,
        BUSY_B = 2'd2
    } arb_state_e;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_ADDR_W       = 11;
    localparam int DEF_DEPTH        = 2048;
    localparam int DEF_WAIT_STATES  = 0;
    localparam int DEF_STARVE_LIMIT = 4;

    // Wait counter and starve counter both cover 0..15
    localparam int CNT_W = 4;

    // Saturating increment used by the starve counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        logic [CNT_W-1:0] res;
        if (v >= lim) begin
            res = lim;
        end else begin
            res = v + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/avr_ram_core.sv
// Single-port synchronous RAM, read-first, with one registered read-data
// output per requester so each port keeps its last read word independently.
// Out-of-range addresses drop writes and read back zero. Reset clears only
// the output registers, never the array.
module avr_ram_core
    import avr_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_en,
    input  logic              i_we,
    input  logic              i_sel_b,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_di,
    output logic [DATA_W-1:0] o_do_a,
    output logic [DATA_W-1:0] o_do_b
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_rd;

    assign w_in_range = ({1'b0, i_addr} < (ADDR_W+1)'(DEPTH));
    assign w_idx      = i_addr[IDX_W-1:0];
    assign w_rd       = w_in_range ? r_mem[w_idx] : '0;

    // Array write; a write coinciding with reset is discarded
    always_ff @(posedge CLK) begin
        if (!RST && i_en && i_we && w_in_range) begin
            r_mem[w_idx] <= i_di;
        end
    end

    // Read data capture into the requesting port's output register
    always_ff @(posedge CLK) begin
        if (RST) begin
            o_do_a <= '0;
            o_do_b <= '0;
        end else if (i_en && !i_we) begin
            if (i_sel_b) begin
                o_do_b <= w_rd;
            end else begin
                o_do_a <= w_rd;
            end
        end
    end

endmodule

// File: rtl/avr_dmem_arb.sv
// Two-port arbiter in front of a single-port data memory. Port A is the CPU
// (stalled while its access is pending), port B is a loader/debug master
// (acknowledged with a one-cycle pulse). A wins arbitration unless B has lost
// STARVE_LIMIT times in a row. Optional wait states stretch every access.
module avr_dmem_arb
    import avr_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int WAIT_STATES  = DEF_WAIT_STATES,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_di,
    output logic [DATA_W-1:0] a_do,
    output logic              a_stall,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_di,
    output logic [DATA_W-1:0] b_do,
    output logic              b_ack
);

    localparam logic [CNT_W-1:0] WS_L  = CNT_W'(WAIT_STATES);
    localparam logic [CNT_W-1:0] LIM_L = CNT_W'(STARVE_LIMIT);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [CNT_W-1:0]  r_wait;
    logic [CNT_W-1:0]  w_wait_nxt;
    logic [CNT_W-1:0]  r_starve;
    logic [CNT_W-1:0]  w_starve_nxt;
    logic              r_b_ack;
    logic              w_done_a;
    logic              w_done_b;
    logic              w_ram_en;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_di;

    // Next-state, counters and completion strobes for the arbitration FSM
    always_comb begin
        w_state_nxt  = r_state;
        w_wait_nxt   = r_wait;
        w_starve_nxt = r_starve;
        w_done_a     = 1'b0;
        w_done_b     = 1'b0;
        case (r_state)
            IDLE: begin
                // A also wins when B is not asking, so a saturated starve
                // count can never lock the CPU out once B has gone away.
                if (a_req && ((r_starve < LIM_L) || !b_req)) begin
                    if (b_req) begin
                        w_starve_nxt = sat_inc(r_starve, LIM_L);
                    end else begin
                        w_starve_nxt = r_starve;
                    end
                    if (WS_L == 4'd0) begin
                        w_done_a    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = BUSY_A;
                        w_wait_nxt  = WS_L;
                    end
                end else if (b_req) begin
                    w_starve_nxt = 4'd0;
                    if (WS_L == 4'd0) begin
                        w_done_b    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = BUSY_B;
                        w_wait_nxt  = WS_L;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY_A: begin
                if (!a_req) begin
                    w_state_nxt = IDLE;
                    w_wait_nxt  = 4'd0;
                end else if (r_wait <= 4'd1) begin
                    // Counter reaches zero on this edge: the access completes
                    w_done_a    = 1'b1;
                    w_state_nxt = IDLE;
                    w_wait_nxt  = 4'd0;
                end else begin
                    w_wait_nxt  = r_wait - 4'd1;
                end
            end
            BUSY_B: begin
                if (!b_req) begin
                    w_state_nxt = IDLE;
                    w_wait_nxt  = 4'd0;
                end else if (r_wait <= 4'd1) begin
                    w_done_b    = 1'b1;
                    w_state_nxt = IDLE;
                    w_wait_nxt  = 4'd0;
                end else begin
                    w_wait_nxt  = r_wait - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_wait_nxt  = 4'd0;
            end
        endcase
    end

    // FSM state, wait counter and starve counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_wait   <= 4'd0;
            r_starve <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_wait   <= w_wait_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    // One-cycle acknowledge following each completed B access
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_b_ack <= 1'b0;
        end else begin
            r_b_ack <= w_done_b;
        end
    end

    // Memory port steering: the completing requester owns the array this edge
    always_comb begin
        w_ram_en   = w_done_a || w_done_b;
        w_ram_we   = 1'b0;
        w_ram_addr = '0;
        w_ram_di   = '0;
        if (w_done_b) begin
            w_ram_we   = b_we;
            w_ram_addr = b_addr;
            w_ram_di   = b_di;
        end else begin
            w_ram_we   = a_we;
            w_ram_addr = a_addr;
            w_ram_di   = a_di;
        end
    end

    assign a_stall = a_req && !w_done_a;
    assign b_ack   = r_b_ack;

    avr_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .CLK     (CLK),
        .RST     (RST),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_sel_b (w_done_b),
        .i_addr  (w_ram_addr),
        .i_di    (w_ram_di),
        .o_do_a  (a_do),
        .o_do_b  (b_do)
    );

endmodule

// File: tb/tb_avr_dmem_arb.sv
// Self-checking bench for avr_dmem_arb: three instances (0, 2 and 3 wait
// states), a table of directed accesses, hand sequences for starvation,
// reset-during-write and abandoned requests, then random traffic checked
// against a memory-array model with latency rules.
module tb_avr_dmem_arb;

    localparam int NI = 3;
    localparam int AW = 12;
    localparam int DP = 2048;

    logic clk = 1'b0;
    logic rst;
    logic       a_req [NI];
    logic       a_we  [NI];
    logic [AW-1:0] a_addr [NI];
    logic [7:0] a_di  [NI];
    logic [7:0] a_do  [NI];
    logic       a_stall [NI];
    logic       b_req [NI];
    logic       b_we  [NI];
    logic [AW-1:0] b_addr [NI];
    logic [7:0] b_di  [NI];
    logic [7:0] b_do  [NI];
    logic       b_ack [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        avr_dmem_arb #(
            .DATA_W       (8),
            .ADDR_W       (AW),
            .DEPTH        (DP),
            .WAIT_STATES  ((g == 0) ? 0 : g + 1),
            .STARVE_LIMIT (4)
        ) u_dut (
            .CLK     (clk),
            .RST     (rst),
            .a_req   (a_req[g]),
            .a_we    (a_we[g]),
            .a_addr  (a_addr[g]),
            .a_di    (a_di[g]),
            .a_do    (a_do[g]),
            .a_stall (a_stall[g]),
            .b_req   (b_req[g]),
            .b_we    (b_we[g]),
            .b_addr  (b_addr[g]),
            .b_di    (b_di[g]),
            .b_do    (b_do[g]),
            .b_ack   (b_ack[g])
        );
    end

    // Reference model: memory contents and last read word per port
    logic [7:0] mem_m [NI][DP];
    logic [7:0] ado_m [NI];
    logic [7:0] bdo_m [NI];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int inst;
        bit pb;
        bit we;
        int addr;
        int di;
        int exp_rd;
    } vec_t;

    vec_t vec [14];

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : i + 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            ado_m[i] = 8'h00;
            bdo_m[i] = 8'h00;
        end
    endtask

    // One access on one port of one instance, with no competing requester
    task automatic access(input int i, input bit pb, input bit we, input int addr,
                          input int di, output int rd);
        int  cyc;
        bit  done;
        int  exp_rd;
        exp_rd = (addr < DP) ? int'(mem_m[i][addr]) : 0;
        @(negedge clk);
        if (!pb) begin
            a_req[i] = 1'b1; a_we[i] = we; a_addr[i] = AW'(addr); a_di[i] = 8'(di);
        end else begin
            b_req[i] = 1'b1; b_we[i] = we; b_addr[i] = AW'(addr); b_di[i] = 8'(di);
        end
        cyc  = 0;
        done = 1'b0;
        if (!pb) begin
            while (!done && cyc < 40) begin
                #1;
                if (!a_stall[i]) done = 1'b1;
                else cyc++;
                @(negedge clk);
            end
            a_req[i] = 1'b0;
            check($sformatf("a_done[%0d]", i), int'(done), 1);
            check($sformatf("a_stall_cycles[%0d]", i), cyc, ws_of(i));
        end else begin
            while (!done && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (b_ack[i]) done = 1'b1;
            end
            b_req[i] = 1'b0;
            check($sformatf("b_ack_seen[%0d]", i), int'(done), 1);
            check($sformatf("b_latency[%0d]", i), cyc, ws_of(i) + 1);
        end
        if (we) begin
            if (addr < DP) mem_m[i][addr] = 8'(di);
        end else if (pb) begin
            bdo_m[i] = 8'(exp_rd);
        end else begin
            ado_m[i] = 8'(exp_rd);
        end
        check($sformatf("a_do[%0d]@%0h", i, addr), int'(a_do[i]), int'(ado_m[i]));
        check($sformatf("b_do[%0d]@%0h", i, addr), int'(b_do[i]), int'(bdo_m[i]));
        rd = pb ? int'(b_do[i]) : int'(a_do[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd;
        int acks;
        int ack_k;
        int stall_pat;
        int r;
        int addr;

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            a_req[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_di[i] = 8'h00;
            b_req[i] = 1'b0; b_we[i] = 1'b0; b_addr[i] = '0; b_di[i] = 8'h00;
            ado_m[i] = 8'h00; bdo_m[i] = 8'h00;
            for (int k = 0; k < DP; k++) mem_m[i][k] = 8'h00;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_a_do[%0d]", i), int'(a_do[i]), 0);
            check($sformatf("rst_b_do[%0d]", i), int'(b_do[i]), 0);
            check($sformatf("rst_b_ack[%0d]", i), int'(b_ack[i]), 0);
            check($sformatf("rst_a_stall[%0d]", i), int'(a_stall[i]), 0);
        end

        // Directed table: {inst, port B, write, addr, data, expected read or -1}
        vec[0]  = '{0, 1'b0, 1'b1, 'h010, 'h5A, -1};
        vec[1]  = '{0, 1'b0, 1'b0, 'h010, 0,    'h5A};
        vec[2]  = '{0, 1'b1, 1'b1, 2048,  'hFF, -1};
        vec[3]  = '{0, 1'b1, 1'b0, 2048,  0,    'h00};
        vec[4]  = '{0, 1'b0, 1'b0, 'h000, 0,    'h00};
        vec[5]  = '{0, 1'b1, 1'b1, 'h7FF, 'hC3, -1};
        vec[6]  = '{0, 1'b0, 1'b0, 'h7FF, 0,    'hC3};
        vec[7]  = '{0, 1'b1, 1'b0, 'h010, 0,    'h5A};
        vec[8]  = '{1, 1'b1, 1'b1, 'h020, 'h33, -1};
        vec[9]  = '{1, 1'b0, 1'b0, 'h020, 0,    'h33};
        vec[10] = '{1, 1'b0, 1'b1, 'h050, 'h44, -1};
        vec[11] = '{1, 1'b1, 1'b0, 'h050, 0,    'h44};
        vec[12] = '{2, 1'b0, 1'b1, 'h040, 'h11, -1};
        vec[13] = '{2, 1'b1, 1'b0, 'h040, 0,    'h11};
        for (int v = 0; v < 14; v++) begin
            access(vec[v].inst, vec[v].pb, vec[v].we, vec[v].addr, vec[v].di, rd);
            if (vec[v].exp_rd >= 0) check($sformatf("vec%0d_rd", v), rd, vec[v].exp_rd);
        end

        // Starvation: A and B both hold requests on the zero-wait instance
        @(negedge clk);
        a_req[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = AW'('h010);
        b_req[0] = 1'b1; b_we[0] = 1'b0; b_addr[0] = AW'('h7FF);
        acks = 0; ack_k = -1; stall_pat = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (a_stall[0]) stall_pat = stall_pat | (1 << k);
            @(negedge clk);
            if (b_ack[0]) begin
                acks++;
                if (ack_k < 0) ack_k = k;
                b_req[0] = 1'b0;
            end
        end
        a_req[0] = 1'b0;
        ado_m[0] = mem_m[0]['h010];
        bdo_m[0] = mem_m[0]['h7FF];
        check("starve_ack_edge", ack_k, 4);
        check("starve_ack_count", acks, 1);
        check("starve_stall_pattern", stall_pat, 'h10);
        check("starve_b_do", int'(b_do[0]), int'(bdo_m[0]));
        check("starve_a_do", int'(a_do[0]), int'(ado_m[0]));

        // Reset on the completion edge of a 3-wait-state A write
        @(negedge clk);
        a_req[2] = 1'b1; a_we[2] = 1'b1; a_addr[2] = AW'('h040); a_di[2] = 8'h77;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_req[2] = 1'b0; a_we[2] = 1'b0;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rstw_a_do[%0d]", i), int'(a_do[i]), 0);
            check($sformatf("rstw_b_do[%0d]", i), int'(b_do[i]), 0);
            check($sformatf("rstw_b_ack[%0d]", i), int'(b_ack[i]), 0);
            ado_m[i] = 8'h00;
            bdo_m[i] = 8'h00;
        end
        access(2, 1'b0, 1'b0, 'h040, 0, rd);
        check("rstw_array_kept", rd, 'h11);

        // B request abandoned while BUSY_B on the 2-wait-state instance
        @(negedge clk);
        b_req[1] = 1'b1; b_we[1] = 1'b1; b_addr[1] = AW'('h050); b_di[1] = 8'hEE;
        @(negedge clk);
        b_req[1] = 1'b0; b_we[1] = 1'b0;
        acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (b_ack[1]) acks++;
        end
        check("abandon_no_ack", acks, 0);
        access(1, 1'b0, 1'b0, 'h050, 0, rd);
        check("abandon_array_kept", rd, 'h44);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < NI; i++) begin
            for (int n = 0; n < 40; n++) begin
                r = $urandom_range(0, 9);
                addr = (r == 0) ? DP + $urandom_range(0, 2047) : $urandom_range(0, 31);
                access(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr,
                       $urandom_range(0, 255), rd);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/avr_dmem_arb.md
AVR_DMEM_ARB -- requirements
Module: avr_dmem_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width.
REQ-002 SHALL have parameter ADDR_W, default 11, address width of both ports.
REQ-003 SHALL have parameter DEPTH, default 2048, number of words (DEPTH <= 2**ADDR_W).
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra cycles per access (0..15).
REQ-005 SHALL have parameter STARVE_LIMIT, default 4, consecutive port-B losses before forced B grant (1..15).
REQ-006 SHALL have port CLK  in  1  clock, all logic on rising edge.
REQ-007 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports a_req in 1, a_we in 1, a_addr in ADDR_W, a_di in DATA_W: CPU request, write enable, address, write data.
REQ-009 SHALL have ports a_do out DATA_W (CPU read data) and a_stall out 1 (CPU must hold request and freeze).
REQ-010 SHALL have ports b_req in 1, b_we in 1, b_addr in ADDR_W, b_di in DATA_W: loader/debug request, write enable, address, write data.
REQ-011 SHALL have ports b_do out DATA_W (loader read data) and b_ack out 1 (one-cycle completion pulse).

Function
REQ-012 SHALL contain one single-port storage array; at most one access completes per edge.
REQ-013 SHALL implement state machine IDLE, BUSY_A, BUSY_B with a wait counter.
REQ-014 In IDLE with any request: grant A if a_req and starve count < STARVE_LIMIT, else grant B if b_req.
REQ-015 With WAIT_STATES=0 a granted access SHALL complete at the same edge it is granted; state stays IDLE.
REQ-016 With WAIT_STATES>0 the grant edge SHALL load counter with WAIT_STATES, enter BUSY_x; each edge decrements; completion at the edge where counter is 0, then return to IDLE.
REQ-017 Address, data and we SHALL be sampled at the completion edge; requester holds them stable while pending.
REQ-018 At completion a write SHALL commit x_di to array[x_addr]; a read SHALL register array[x_addr] into x_do, visible the cycle after completion.
REQ-019 x_do SHALL hold its value until that port's next completed read; a write leaves x_do unchanged.
REQ-020 a_stall SHALL be combinational: high when a_req is high and the A access does not complete at the coming edge; low when a_req is low.
REQ-021 With WAIT_STATES=0 and b_req low, a_stall SHALL be constantly 0 (legacy single-cycle CPU timing preserved).
REQ-022 b_ack SHALL be registered, high exactly one cycle after each B completion.
REQ-023 Starve counter SHALL increment (saturating at STARVE_LIMIT) each IDLE arbitration where b_req is high but A is granted, and clear when B is granted.
REQ-024 A request deasserted before completion SHALL be abandoned without array access; the FSM returns to IDLE next edge.
REQ-025 Address >= DEPTH: write dropped, read returns all-zero; handshake timing unchanged.

Reset
REQ-026 RST SHALL have priority over all activity: state IDLE, counter 0, starve count 0, a_do 0, b_do 0, b_ack 0.
REQ-027 A write completing on an edge where RST is high SHALL NOT commit.
REQ-028 Array contents SHALL NOT be cleared by RST; simulation initial contents are zero.

Structure
REQ-029 Package avr_pkg SHALL hold the FSM state enum (IDLE, BUSY_A, BUSY_B) and default parameter constants.
REQ-030 Storage SHALL be sub-module avr_ram_core (single-port, synchronous, read-first, DATA_W x DEPTH); arbitration/FSM in avr_dmem_arb.

Verification
REQ-031 WAIT_STATES=0, A write 0x5A to 0x010, then read 0x010 -> a_stall stays 0, a_do=0x5A one cycle after read edge.
REQ-032 WAIT_STATES=2, A read 0x020 preloaded 0x33 -> a_stall high 2 cycles, a_do=0x33 the cycle after the third edge.
REQ-033 STARVE_LIMIT=4, A and B continuously requesting, WAIT_STATES=0 -> B granted on 5th arbitration, b_ack pulses once, then A resumes.
REQ-034 B write 0xFF to address 2048 (DEPTH=2048), then B read 2048 -> b_ack each time, b_do=0x00, array unchanged.
REQ-035 WAIT_STATES=3, A write 0x77 to 0x040 with RST asserted on the completion edge -> array[0x040] keeps old value, outputs all zero, FSM IDLE.
REQ-036 WAIT_STATES=2, B request dropped during BUSY_B -> no b_ack, no array change, A granted on next request.
